key_input: RTL and testbench

KEY_INPUT -- requirements
Module: key_input

---
 rtl/key_input.sv | 266 ++++++++++++++++++++++++++
 tb/tb_key_input.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_input.sv
// key_input: 4x4 keypad scanner with per-tick debounce feeding an 8-digit
// entry buffer (sign7..sign0, sign0 rightmost).
// Optional build macro KEY_REPEAT_EN: while a key stays held, it is
// re-accepted every REPEAT_TICKS scan ticks. Without it, each press is
// accepted exactly once and REPEAT_TICKS only sizes the shared counter.
//
// Output strobe semantics: key_valid is a single-cycle strobe with no
// back-pressure (no ready). key_code, sign7..sign0 and digit_cnt change on
// the same edge that raises key_valid and hold until the next accept/clear.
module key_input #(
    parameter int SCAN_DIV     = 25000,
    parameter int DEBOUNCE_CNT = 20,
    parameter int REPEAT_TICKS = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic [3:0] sign7,
    output logic [3:0] sign6,
    output logic [3:0] sign5,
    output logic [3:0] sign4,
    output logic [3:0] sign3,
    output logic [3:0] sign2,
    output logic [3:0] sign1,
    output logic [3:0] sign0,
    output logic [3:0] digit_cnt,
    output logic [1:0] dbg_state
);

    // One counter serves both debounce and repeat intervals, so it is sized
    // for the longer of the two.
    localparam int CNT_MAX = (REPEAT_TICKS > DEBOUNCE_CNT) ? REPEAT_TICKS : DEBOUNCE_CNT;
    localparam int DIV_W   = (SCAN_DIV > 0) ? $clog2(SCAN_DIV + 1) : 1;
    localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CNT - 1);
`ifdef KEY_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_TICKS - 1);
`endif

    typedef enum logic [1:0] {
        S_SCAN     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_HELD     = 2'd2,
        S_RELEASE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       col_q, col_d;
    logic [1:0]       key_row_q, key_row_d;
    logic [1:0]       key_col_q, key_col_d;
    logic             key_valid_q, key_valid_d;
    logic [3:0]       key_code_q, key_code_d;
    logic [3:0]       sign_q [8];
    logic [3:0]       sign_d [8];
    logic [3:0]       digit_cnt_q, digit_cnt_d;

    logic             tick;
    logic             row_hit;
    logic [1:0]       row_idx;
    logic [1:0]       col_idx;
    logic [3:0]       held_row_pat;
    logic             accept;
    logic [3:0]       acc_code;

    assign tick         = (div_q == DIV_LAST);
    assign held_row_pat = ~(4'b0001 << key_row_q);
    assign acc_code     = {key_row_q, key_col_q};

    // Decode a single low row and the currently driven column; anything
    // other than exactly one low row counts as no key.
    always_comb begin
        row_hit = 1'b1;
        row_idx = 2'd0;
        case (row_in)
            4'b1110: row_idx = 2'd0;
            4'b1101: row_idx = 2'd1;
            4'b1011: row_idx = 2'd2;
            4'b0111: row_idx = 2'd3;
            default: row_hit = 1'b0;
        endcase
        col_idx = 2'd0;
        case (col_q)
            4'b1101: col_idx = 2'd1;
            4'b1011: col_idx = 2'd2;
            4'b0111: col_idx = 2'd3;
            default: col_idx = 2'd0;
        endcase
    end

    // Scan FSM next state: divider, column rotation, debounce and release.
    always_comb begin
        state_d   = state_q;
        div_d     = tick ? '0 : div_q + 1'b1;
        cnt_d     = cnt_q;
        col_d     = col_q;
        key_row_d = key_row_q;
        key_col_d = key_col_q;
        accept    = 1'b0;

        if (!en) begin
            // Idle: columns released, any pending key forgotten.
            state_d = S_SCAN;
            div_d   = '0;
            cnt_d   = '0;
            col_d   = 4'b1111;
        end else if (col_q == 4'b1111) begin
            // First enabled cycle after idle: restart scanning at column 0.
            col_d = 4'b1110;
            div_d = '0;
        end else if (tick) begin
            case (state_q)
                S_SCAN: begin
                    if (row_hit) begin
                        key_row_d = row_idx;
                        key_col_d = col_idx;
                        cnt_d     = '0;
                        state_d   = S_DEBOUNCE;
                    end else begin
                        col_d = {col_q[2:0], col_q[3]};
                    end
                end
                S_DEBOUNCE: begin
                    if (row_in == held_row_pat) begin
                        if (cnt_q == DEB_LAST) begin
                            accept  = 1'b1;
                            cnt_d   = '0;
                            state_d = S_HELD;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = S_SCAN;
                    end
                end
                S_HELD: begin
                    if (row_in == 4'b1111) begin
                        cnt_d   = '0;
                        state_d = S_RELEASE;
                    end
`ifdef KEY_REPEAT_EN
                    else if (cnt_q == REP_LAST) begin
                        accept = 1'b1;
                        cnt_d  = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end
                S_RELEASE: begin
                    if (row_in == 4'b1111) begin
                        if (cnt_q == DEB_LAST) begin
                            cnt_d   = '0;
                            state_d = S_SCAN;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        // Release bounced: back to held, interval restarts.
                        cnt_d   = '0;
                        state_d = S_HELD;
                    end
                end
                default: state_d = S_SCAN;
            endcase
        end
    end

    // Entry buffer update on accept; clr wins over a same-cycle accept.
    always_comb begin
        key_valid_d = accept;
        key_code_d  = key_code_q;
        digit_cnt_d = digit_cnt_q;
        for (int i = 0; i < 8; i++) begin
            sign_d[i] = sign_q[i];
        end

        if (accept) begin
            key_code_d = acc_code;
            if (acc_code <= 4'd10) begin
                for (int i = 7; i > 0; i--) begin
                    sign_d[i] = sign_q[i-1];
                end
                sign_d[0] = acc_code;
                if (digit_cnt_q != 4'd8) begin
                    digit_cnt_d = digit_cnt_q + 1'b1;
                end
            end else if (acc_code == 4'd11) begin
                for (int i = 0; i < 7; i++) begin
                    sign_d[i] = sign_q[i+1];
                end
                sign_d[7] = 4'd0;
                if (digit_cnt_q != 4'd0) begin
                    digit_cnt_d = digit_cnt_q - 1'b1;
                end
            end else if (acc_code == 4'd12) begin
                for (int i = 0; i < 8; i++) begin
                    sign_d[i] = 4'd0;
                end
                digit_cnt_d = 4'd0;
            end
        end

        if (clr) begin
            for (int i = 0; i < 8; i++) begin
                sign_d[i] = 4'd0;
            end
            digit_cnt_d = 4'd0;
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_SCAN;
            div_q       <= '0;
            cnt_q       <= '0;
            col_q       <= 4'b1110;
            key_row_q   <= 2'd0;
            key_col_q   <= 2'd0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'd0;
            digit_cnt_q <= 4'd0;
            for (int i = 0; i < 8; i++) begin
                sign_q[i] <= 4'd0;
            end
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            col_q       <= col_d;
            key_row_q   <= key_row_d;
            key_col_q   <= key_col_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            digit_cnt_q <= digit_cnt_d;
            for (int i = 0; i < 8; i++) begin
                sign_q[i] <= sign_d[i];
            end
        end
    end

    assign col_out   = col_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign digit_cnt = digit_cnt_q;
    assign dbg_state = state_q;
    assign sign0     = sign_q[0];
    assign sign1     = sign_q[1];
    assign sign2     = sign_q[2];
    assign sign3     = sign_q[3];
    assign sign4     = sign_q[4];
    assign sign5     = sign_q[5];
    assign sign6     = sign_q[6];
    assign sign7     = sign_q[7];

endmodule

// File: tb/tb_key_input.sv
// tb_key_input: keypad model, press/release drivers, pulse monitor with an
// expected-code queue and a digit-buffer reference model.
module tb_key_input;

    localparam int TICK = 5;  // clk cycles per scan tick with SCAN_DIV=4

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b1;
    logic       clr = 1'b0;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic       key_valid;
    logic [3:0] key_code;
    logic [3:0] sign7, sign6, sign5, sign4, sign3, sign2, sign1, sign0;
    logic [3:0] digit_cnt;
    logic [1:0] dbg_state;

    logic [15:0] keys_down = '0;

    int err_cnt   = 0;
    int chk_cnt   = 0;
    int pulse_cnt = 0;
    int mon_cyc   = 0;

    logic [3:0] exp_q[$];
    int         pulse_cyc[$];
    int         m_dig[8];
    int         m_cnt;
    logic [3:0] mon_code;

    key_input #(
        .SCAN_DIV    (4),
        .DEBOUNCE_CNT(3),
        .REPEAT_TICKS(6)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .clr      (clr),
        .row_in   (row_in),
        .col_out  (col_out),
        .key_valid(key_valid),
        .key_code (key_code),
        .sign7    (sign7),
        .sign6    (sign6),
        .sign5    (sign5),
        .sign4    (sign4),
        .sign3    (sign3),
        .sign2    (sign2),
        .sign1    (sign1),
        .sign0    (sign0),
        .digit_cnt(digit_cnt),
        .dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Keypad matrix: a pressed key pulls its row low while its column is driven.
    always_comb begin
        row_in = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys_down[4*r+c] && !col_out[c]) row_in[r] = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference digit buffer
    function automatic void model_clear();
        for (int i = 0; i < 8; i++) m_dig[i] = 0;
        m_cnt = 0;
    endfunction

    function automatic void model_apply(input int code);
        if (code <= 10) begin
            for (int i = 7; i > 0; i--) m_dig[i] = m_dig[i-1];
            m_dig[0] = code;
            m_cnt = (m_cnt < 8) ? m_cnt + 1 : 8;
        end else if (code == 11) begin
            for (int i = 0; i < 7; i++) m_dig[i] = m_dig[i+1];
            m_dig[7] = 0;
            m_cnt = (m_cnt > 0) ? m_cnt - 1 : 0;
        end else if (code == 12) begin
            model_clear();
        end
    endfunction

    function automatic logic [31:0] model_pack();
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v[4*i +: 4] = m_dig[i][3:0];
        return v;
    endfunction

    function automatic logic [31:0] dut_pack();
        return {sign7, sign6, sign5, sign4, sign3, sign2, sign1, sign0};
    endfunction

    // Monitor: every key_valid pulse must match the next expected code.
    initial begin
        model_clear();
        forever begin
            @(posedge clk);
            #1;
            mon_cyc++;
            if (!rst) begin
                model_clear();
            end else if (key_valid) begin
                pulse_cnt++;
                pulse_cyc.push_back(mon_cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", {31'd0, key_valid}, 32'd0);
                end else begin
                    mon_code = exp_q.pop_front();
                    model_apply(int'(mon_code));
                    if (clr) model_clear();
                    check("key_code", {28'd0, key_code}, {28'd0, mon_code});
                    check("signs_at_valid", dut_pack(), model_pack());
                    check("cnt_at_valid", {28'd0, digit_cnt}, m_cnt);
                end
            end else if (clr) begin
                model_clear();
            end
        end
    end

    // Driver tasks
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_pulse(input int base, input string tag);
        for (int k = 0; k < 300 && pulse_cnt == base; k++) @(negedge clk);
        check(tag, pulse_cnt - base, 1);
    endtask

    task automatic check_buf(input string tag);
        check({tag, "_signs"}, dut_pack(), model_pack());
        check({tag, "_cnt"}, {28'd0, digit_cnt}, m_cnt);
    endtask

    task automatic press(input int code, input int hold_ticks);
        int base;
        base = pulse_cnt;
        exp_q.push_back(code[3:0]);
        keys_down = 16'b1 << code;
        wait_pulse(base, "press_pulse");
        wait_clk(hold_ticks * TICK);
        keys_down = '0;
        wait_clk(8 * TICK);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_col"}, {28'd0, col_out}, 32'hE);
        check({tag, "_valid"}, {31'd0, key_valid}, 32'd0);
        check({tag, "_code"}, {28'd0, key_code}, 32'd0);
        check({tag, "_signs"}, dut_pack(), 32'd0);
        check({tag, "_cnt"}, {28'd0, digit_cnt}, 32'd0);
    endtask

    // Stimulus
    initial begin
        int base;
        logic [3:0] exp_col [4];
        exp_col[0] = 4'b1101; exp_col[1] = 4'b1011; exp_col[2] = 4'b0111; exp_col[3] = 4'b1110;

        // Reset and free-running column scan
        wait_clk(3);
        check_reset_outputs("reset");
        rst = 1'b1;
        check("scan_col0", {28'd0, col_out}, 32'hE);
        for (int k = 0; k < 4; k++) begin
            wait_clk(TICK);
            check("scan_rotate", {28'd0, col_out}, {28'd0, exp_col[k]});
        end

        // Code 6 (row 1, column 2): one pulse, column frozen while held
        base = pulse_cnt;
        exp_q.push_back(4'd6);
        keys_down = 16'b1 << 6;
        wait_pulse(base, "k6_pulse");
        check("k6_col_frozen", {28'd0, col_out}, 32'hB);
        wait_clk(5 * TICK);
        check("k6_col_still", {28'd0, col_out}, 32'hB);
        keys_down = '0;
        wait_clk(8 * TICK);
        check("k6_pulses", pulse_cnt - base, 1);
        check("k6_code", {28'd0, key_code}, 32'd6);
        check("k6_signs", dut_pack(), 32'h6);
        check("k6_cnt", {28'd0, digit_cnt}, 32'd1);

        // Clear, digits 1..9, backspace
        press(12, 1);
        check_buf("clear12");
        for (int d = 1; d <= 9; d++) press(d, 1);
        check("seq9_signs", dut_pack(), 32'h23456789);
        check("seq9_cnt", {28'd0, digit_cnt}, 32'd8);
        press(11, 1);
        check("bksp_signs", dut_pack(), 32'h02345678);
        check("bksp_cnt", {28'd0, digit_cnt}, 32'd7);

        // Short bounce and two rows low together: no key
        base = pulse_cnt;
        keys_down = 16'b1 << 9;
        wait_clk(2 * TICK);
        keys_down = '0;
        wait_clk(8 * TICK);
        check("bounce_pulses", pulse_cnt - base, 0);
        keys_down = (16'b1 << 1) | (16'b1 << 9);
        wait_clk(20 * TICK);
        keys_down = '0;
        wait_clk(8 * TICK);
        check("tworow_pulses", pulse_cnt - base, 0);
        check_buf("noise");

        // Scan disabled: columns released, no key, buffer kept
        en = 1'b0;
        wait_clk(2);
        check("en_off_col", {28'd0, col_out}, 32'hF);
        keys_down = 16'b1 << 7;
        wait_clk(10 * TICK);
        keys_down = '0;
        check("en_off_pulses", pulse_cnt - base, 0);
        check_buf("en_off");
        en = 1'b1;
        wait_clk(1);
        check("en_restart_col", {28'd0, col_out}, 32'hE);
        wait_clk(TICK);
        check("en_first_rotate", {28'd0, col_out}, 32'hD);
        wait_clk(4 * TICK);

        // Randomized presses against the reference buffer
        for (int n = 0; n < 25; n++) begin
            press(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
            check_buf("rand");
        end

        // clr held across the accept of code 5
        press(7, 1);
        base = pulse_cnt;
        exp_q.push_back(4'd5);
        clr = 1'b1;
        keys_down = 16'b1 << 5;
        wait_pulse(base, "clr_pulse");
        wait_clk(1);
        clr = 1'b0;
        check("clr_code", {28'd0, key_code}, 32'd5);
        check("clr_signs", dut_pack(), 32'd0);
        check("clr_cnt", {28'd0, digit_cnt}, 32'd0);
        keys_down = '0;
        wait_clk(8 * TICK);

        // Long hold of code 3: repeats only when auto-repeat is built in
        pulse_cyc.delete();
        base = pulse_cnt;
`ifdef KEY_REPEAT_EN
        repeat (3) exp_q.push_back(4'd3);
`else
        exp_q.push_back(4'd3);
`endif
        keys_down = 16'b1 << 3;
        wait_pulse(base, "hold_first");
        wait_clk(14 * TICK);
        keys_down = '0;
        wait_clk(8 * TICK);
`ifdef KEY_REPEAT_EN
        check("hold_pulses", pulse_cyc.size(), 3);
        if (pulse_cyc.size() == 3) begin
            check("repeat_gap1", pulse_cyc[1] - pulse_cyc[0], 6 * TICK);
            check("repeat_gap2", pulse_cyc[2] - pulse_cyc[1], 6 * TICK);
        end
`else
        check("hold_pulses", pulse_cyc.size(), 1);
`endif
        check_buf("hold");

        // Reset in the middle of a debounce discards the key
        rst = 1'b0;
        keys_down = 16'b1 << 0;
        wait_clk(2);
        rst = 1'b1;
        base = pulse_cnt;
        wait_clk(12);
        rst = 1'b0;
        wait_clk(1);
        check_reset_outputs("mid_rst");
        keys_down = '0;
        wait_clk(2);
        rst = 1'b1;
        wait_clk(10 * TICK);
        check("mid_rst_pulses", pulse_cnt - base, 0);
        check_buf("mid_rst");

        check("exp_q_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    // Hang guard
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
